// File: rtl/divisor_seq_4bits.sv
// Sequential restoring divider for unsigned 4-bit operands.
// One quotient bit per cycle, MSB first; divide-by-zero flagged without iterating.

module subtrator_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] diff_c,
  output logic       borrow_c
);

  localparam int unsigned W = 4;

  logic [W:0] wide_c;

  // The extra MSB of the widened difference is the borrow, i.e. (a < b).
  always_comb begin
    wide_c   = {1'b0, a} - {1'b0, b};
    diff_c   = wide_c[W-1:0];
    borrow_c = wide_c[W];
  end

endmodule

module divisor_seq_4bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividendo,
  input  logic [3:0] divisor,
  output logic [3:0] quociente,
  output logic [3:0] resto,
  output logic       busy,
  output logic       done,
  output logic       erro_div0
);

  localparam int unsigned W  = 4;
  localparam int unsigned SW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [SW-1:0]  step;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   quo_q;
  logic [W-1:0]   dvs_q;

  logic [W-1:0]   rem_shift_c;
  logic [W-1:0]   diff_c;
  logic           borrow_c;
  logic [W-1:0]   rem_next_c;
  logic [W-1:0]   quo_next_c;

  // Partial remainder stays below min(divisor, 8), so the shift never loses a bit.
  assign rem_shift_c = {rem_q[W-2:0], quo_q[W-1]};

  subtrator_4bits u_sub (
    .a        (rem_shift_c),
    .b        (dvs_q),
    .diff_c   (diff_c),
    .borrow_c (borrow_c)
  );

  assign quo_next_c = {quo_q[W-2:0], ~borrow_c};
  assign rem_next_c = borrow_c ? rem_shift_c : diff_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quociente <= '0;
      resto     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      erro_div0 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvs_q     <= divisor;
            quo_q     <= dividendo;
            rem_q     <= '0;
            step      <= '0;
            erro_div0 <= 1'b0;
            busy      <= 1'b1;
            if (divisor == '0) begin
              quociente <= '1;
              resto     <= dividendo;
              erro_div0 <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              state     <= CALC;
            end
          end
        end
        CALC: begin
          quo_q <= quo_next_c;
          rem_q <= rem_next_c;
          step  <= step + SW'(1);
          // Final iteration publishes the result directly from the next-state values.
          if (step == SW'(W - 1)) begin
            quociente <= quo_next_c;
            resto     <= rem_next_c;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_seq_4bits.sv
// Scoreboard bench for divisor_seq_4bits: directed cases plus a full operand sweep.

module tb_divisor_seq_4bits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividendo;
  logic [3:0] divisor;
  logic [3:0] quociente;
  logic [3:0] resto;
  logic       busy;
  logic       done;
  logic       erro_div0;

  divisor_seq_4bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .quociente (quociente),
    .resto     (resto),
    .busy      (busy),
    .done      (done),
    .erro_div0 (erro_div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
    int         cyc;
    int         a;
    int         b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done cyc=%0d got q=%0d r=%0d err=%0b", cyc, quociente, resto, erro_div0);
      end else begin
        e = sb.pop_front();
        if (quociente !== e.q || resto !== e.r || erro_div0 !== e.err || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL result %0d/%0d got q=%0d r=%0d err=%0b cyc=%0d want q=%0d r=%0d err=%0b cyc=%0d",
                   e.a, e.b, quociente, resto, erro_div0, cyc, e.q, e.r, e.err, e.cyc);
        end
      end
    end
  end

  task automatic push_exp(input int a, input int b, input int e0);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = 4'hF; e.r = 4'(a); e.err = 1'b1; e.cyc = e0;
    end else begin
      e.q = 4'(a / b); e.r = 4'(a % b); e.err = 1'b0; e.cyc = e0 + 4;
    end
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({quociente, resto, busy, done, erro_div0} !== 11'd0) begin
      miscompares++;
      $display("FAIL %s got q=%0d r=%0d busy=%0b done=%0b err=%0b want all zero",
               name, quociente, resto, busy, done, erro_div0);
    end
  endtask

  // Call at a falling edge; start is seen by the next rising edge (E0).
  task automatic issue(input int a, input int b);
    int e0;
    #1;
    start = 1'b1;
    dividendo = 4'(a);
    divisor = 4'(b);
    e0 = cyc + 1;
    push_exp(a, b, e0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start %0d/%0d got busy=%0b want 1", a, b, busy);
    end
    #1;
    start = 1'b0;
    dividendo = 4'($urandom);
    divisor = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20);
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout got busy=%0b want 0", busy);
    end
  endtask

  initial begin
    int e0;
    rst_n = 1'b0;
    start = 1'b1;
    dividendo = 4'd5;
    divisor = 4'd1;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // 13/4 accepted on the first edge after reset release
    issue(13, 4);   wait_idle();
    issue(15, 1);   wait_idle();
    issue(3, 9);    wait_idle();
    issue(15, 15);  wait_idle();
    issue(15, 2);   wait_idle();
    issue(7, 0);    wait_idle();
    issue(6, 3);    wait_idle();

    // start kept high with other operands through CALC and DONE
    #1;
    start = 1'b1; dividendo = 4'd13; divisor = 4'd4;
    e0 = cyc + 1;
    push_exp(13, 4, e0);
    @(negedge clk);
    #1;
    dividendo = 4'd2; divisor = 4'd1;
    while (cyc < e0 + 5) @(negedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // start held continuously: second division accepted right after DONE
    #1;
    start = 1'b1; dividendo = 4'd6; divisor = 4'd2;
    e0 = cyc + 1;
    push_exp(6, 2, e0);
    push_exp(6, 2, e0 + 6);
    while (cyc < e0 + 6) @(negedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // reset at E2 aborts a running division without a done pulse
    #1;
    start = 1'b1; dividendo = 4'd13; divisor = 4'd4;
    e0 = cyc + 1;
    @(negedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("abort_reset");
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    issue(9, 2);    wait_idle();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(a, b);
        wait_idle();
      end
    end

    repeat (8) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divisor_seq_4bits.md
DIVISOR_SEQ_4BITS -- requirements
Module: divisor_seq_4bits

Interface
REQ-001 Parameters: none; all widths fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividendo  input  4  unsigned dividend; sampled with accepted start.
REQ-006 divisor  input  4  unsigned divisor; sampled with accepted start.
REQ-007 quociente  output  4  registered quotient; valid from done until next accepted start.
REQ-008 resto  output  4  registered remainder; same validity as quociente.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 erro_div0  output  1  high with done when the divisor was zero; held until next accepted start.

Function
REQ-012 Restoring division of unsigned 4-bit operands; one quotient bit per cycle, MSB first.
REQ-013 Trial subtraction SHALL use one instance of subtrator_4bits, wired so that difference = partial remainder − divisor and borrow-out = (partial remainder < divisor).
REQ-014 FSM states: IDLE, CALC, DONE; 2-bit step counter used only in CALC.
REQ-015 IDLE: start=1 at edge E0 latches operands, clears erro_div0, goes to CALC with step=0 (divisor≠0) or to DONE (divisor=0).
REQ-016 CALC iteration: R' = {R[2:0], Q[3]}, Q shifted left; if borrow=0 then R = R' − divisor and Q[0]=1, else R = R' and Q[0]=0.
REQ-017 CALC runs exactly 4 iterations, on edges E1..E4; after E4 go to DONE; quociente/resto load from Q/R on E4.
REQ-018 Partial remainder before each shift is < min(divisor, 8), so 4-bit R never overflows; no 5th bit.
REQ-019 DONE lasts exactly one cycle: done=1, busy=1; next edge returns to IDLE.
REQ-020 Latency: done high in cycle after E4 (normal) or after E0 (divisor zero).
REQ-021 Divisor zero: quociente=4'hF, resto=dividendo, erro_div0=1, no CALC cycles.
REQ-022 start while in CALC or DONE is ignored; operands and progress unaffected.
REQ-023 start held high continuously: new division accepted on first edge in IDLE after DONE.
REQ-024 quociente, resto, erro_div0 change only on completion or reset; stable during CALC.
REQ-025 Operand inputs changing after acceptance have no effect on the running division.

Reset
REQ-026 rst_n=0 on an edge: state IDLE, step=0, internal R/Q=0, quociente=0, resto=0, busy=0, done=0, erro_div0=0.
REQ-027 Reset overrides start and any operation in progress; no done pulse is produced for an aborted division.
REQ-028 First start accepted on the first edge with rst_n=1.

Verification
REQ-029 13/4: start one cycle -> busy next cycle, done exactly in cycle after E4, quociente=3, resto=1, erro_div0=0.
REQ-030 15/1 -> quociente=15, resto=0; 3/9 -> quociente=0, resto=3; 15/15 -> quociente=1, resto=0; 15/2 -> quociente=7, resto=1.
REQ-031 7/0 -> done in cycle after E0, erro_div0=1, quociente=4'hF, resto=7; next 6/3 clears erro_div0, gives quociente=2, resto=0.
REQ-032 Start 13/4, then start=1 with 2/1 during CALC and DONE -> result stays 3/1; exactly one done pulse.
REQ-033 Start 13/4, rst_n=0 at E2 -> all outputs zero next cycle, no done; after release 9/2 -> quociente=4, resto=1.
REQ-034 Exhaustive 256-pair sweep vs. integer reference model: quotient, remainder, erro_div0 and done timing all match.
